dmem_arbiter: RTL

Two-requester arbiter sharing the single data-memory port between the CPU data path (requester 0) and an auxiliary master such as a program loader or debug/DMA engine (requester 1). Each requester uses a valid/ready request handshake. One transaction is in flight at a time. The block drives the data memory's address, write-data, memOp and write-enable lines, captures read data and returns it to the winning requester with a completion pulse. It sits between the CPU and DataMem at system level.

---
 rtl/dmem_arbiter_if.sv | 49 ++++
 rtl/dmem_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
//------------------------------------------------------------------------------
// dmem_arbiter_if : requester handshakes, data-memory bus and status of the arbiter
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              r0_valid, r0_ready, r0_we, r0_done;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata, r0_rdata;
  logic [2:0]        r0_op;
  logic              r1_valid, r1_ready, r1_we, r1_done;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata, r1_rdata;
  logic [2:0]        r1_op;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din, mem_dout;
  logic [2:0]        mem_op;
  logic [1:0]        grant;
  logic              busy;

  // Arbiter side
  modport slave (
    input  r0_valid, r0_addr, r0_wdata, r0_op, r0_we,
    output r0_ready, r0_done, r0_rdata,
    input  r1_valid, r1_addr, r1_wdata, r1_op, r1_we,
    output r1_ready, r1_done, r1_rdata,
    output mem_en, mem_addr, mem_din, mem_op, mem_we,
    input  mem_dout,
    output grant, busy
  );

  // Requester / memory side
  modport master (
    output r0_valid, r0_addr, r0_wdata, r0_op, r0_we,
    input  r0_ready, r0_done, r0_rdata,
    output r1_valid, r1_addr, r1_wdata, r1_op, r1_we,
    input  r1_ready, r1_done, r1_rdata,
    input  mem_en, mem_addr, mem_din, mem_op, mem_we,
    output mem_dout,
    input  grant, busy
  );
endinterface

`default_nettype wire

// File: rtl/dmem_arbiter.sv
//------------------------------------------------------------------------------
// dmem_arbiter : two-requester arbiter for the single data-memory port.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-break (fixed r0 priority otherwise).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  wire logic     clock,
  input  wire logic     reset,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [2:0]        r_op;
  logic              r_we;
  logic              r_owner;
  logic [1:0]        r_grant;
  logic              r_busy;
  logic              r_mem_en;
  logic              r_done0, r_done1;
  logic [DATA_W-1:0] r_rdata0, r_rdata1;

  logic              w_idle;
  logic              w_pick1;
  logic              w_rdy0, w_rdy1;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [2:0]        w_op;
  logic              w_we;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = requester 1 won the most recent handshake, so requester 0 wins the next tie
  logic r_last;
  assign w_pick1 = bus.r1_valid && (!bus.r0_valid || !r_last);
`else
  assign w_pick1 = bus.r1_valid && !bus.r0_valid;
`endif

  assign w_idle  = (r_state == IDLE) && reset;
  assign w_rdy0  = w_idle && bus.r0_valid && !w_pick1;
  assign w_rdy1  = w_idle && w_pick1;

  assign w_addr  = w_rdy1 ? bus.r1_addr  : bus.r0_addr;
  assign w_wdata = w_rdy1 ? bus.r1_wdata : bus.r0_wdata;
  assign w_op    = w_rdy1 ? bus.r1_op    : bus.r0_op;
  assign w_we    = w_rdy1 ? bus.r1_we    : bus.r0_we;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_op     <= '0;
      r_we     <= 1'b0;
      r_owner  <= 1'b0;
      r_grant  <= 2'b00;
      r_busy   <= 1'b0;
      r_mem_en <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last   <= 1'b1;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rdy0 || w_rdy1) begin
            r_addr   <= w_addr;
            r_wdata  <= w_wdata;
            r_op     <= w_op;
            r_we     <= w_we;
            r_owner  <= w_rdy1;
            r_grant  <= w_rdy1 ? 2'b10 : 2'b01;
            r_busy   <= 1'b1;
            r_mem_en <= 1'b1;
            r_state  <= ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
            r_last   <= w_rdy1;
`endif
          end
        end
        ISSUE: begin
          r_mem_en <= 1'b0;
          if (r_we) begin
            r_done0 <= !r_owner;
            r_done1 <= r_owner;
            r_state <= DONE;
          end else begin
            r_state <= CAPT;
          end
        end
        CAPT: begin
          if (r_owner) r_rdata1 <= bus.mem_dout;
          else         r_rdata0 <= bus.mem_dout;
          r_done0 <= !r_owner;
          r_done1 <= r_owner;
          r_state <= DONE;
        end
        DONE: begin
          r_done0 <= 1'b0;
          r_done1 <= 1'b0;
          r_grant <= 2'b00;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.r0_ready = w_rdy0;
  assign bus.r1_ready = w_rdy1;
  assign bus.r0_done  = r_done0;
  assign bus.r1_done  = r_done1;
  assign bus.r0_rdata = r_rdata0;
  assign bus.r1_rdata = r_rdata1;
  assign bus.mem_en   = r_mem_en;
  assign bus.mem_addr = r_addr;
  assign bus.mem_din  = r_wdata;
  assign bus.mem_op   = r_op;
  assign bus.mem_we   = r_we;
  assign bus.grant    = r_grant;
  assign bus.busy     = r_busy;

endmodule

`default_nettype wire
